// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment display driver:
//   - active-high segment patterns for the hex digits 0..F
//   - SEG_BLANK (all segments off)
//   - bit positions of segments a..g and the decimal point in the 8-bit word
//   - seg7_pack(): places seven a..g segments plus dp into that 8-bit word
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Active-high patterns, bit0 = a ... bit6 = g
    localparam logic [6:0] SEG_HEX_0 = 7'h3F;
    localparam logic [6:0] SEG_HEX_1 = 7'h06;
    localparam logic [6:0] SEG_HEX_2 = 7'h5B;
    localparam logic [6:0] SEG_HEX_3 = 7'h4F;
    localparam logic [6:0] SEG_HEX_4 = 7'h66;
    localparam logic [6:0] SEG_HEX_5 = 7'h6D;
    localparam logic [6:0] SEG_HEX_6 = 7'h7D;
    localparam logic [6:0] SEG_HEX_7 = 7'h07;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h6F;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h7C;
    localparam logic [6:0] SEG_HEX_C = 7'h39;
    localparam logic [6:0] SEG_HEX_D = 7'h5E;
    localparam logic [6:0] SEG_HEX_E = 7'h79;
    localparam logic [6:0] SEG_HEX_F = 7'h71;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bit positions inside the 8-bit segment word
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Assemble the active-high 8-bit segment word from a..g and dp
    function automatic logic [7:0] seg7_pack(input logic [6:0] segs, input logic dp_on);
        logic [7:0] word;
        word         = 8'h00;
        word[SEG_A]  = segs[0];
        word[SEG_B]  = segs[1];
        word[SEG_C]  = segs[2];
        word[SEG_D]  = segs[3];
        word[SEG_E]  = segs[4];
        word[SEG_F]  = segs[5];
        word[SEG_G]  = segs[6];
        word[SEG_DP] = dp_on;
        return word;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// -----------------------------------------------------------------------------
// seg7_hex_decode
// Combinational hex-to-7-segment decoder (active-high outputs).
// Ports:
//   nibble_i [3:0]  hex digit to decode
//   seg_o    [6:0]  segments a..g (bit0 = a), 1 = lit
// -----------------------------------------------------------------------------
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Look-up of the segment pattern for each hex value
    always_comb begin
        case (nibble_i)
            4'h0:    seg_o = SEG_HEX_0;
            4'h1:    seg_o = SEG_HEX_1;
            4'h2:    seg_o = SEG_HEX_2;
            4'h3:    seg_o = SEG_HEX_3;
            4'h4:    seg_o = SEG_HEX_4;
            4'h5:    seg_o = SEG_HEX_5;
            4'h6:    seg_o = SEG_HEX_6;
            4'h7:    seg_o = SEG_HEX_7;
            4'h8:    seg_o = SEG_HEX_8;
            4'h9:    seg_o = SEG_HEX_9;
            4'hA:    seg_o = SEG_HEX_A;
            4'hB:    seg_o = SEG_HEX_B;
            4'hC:    seg_o = SEG_HEX_C;
            4'hD:    seg_o = SEG_HEX_D;
            4'hE:    seg_o = SEG_HEX_E;
            4'hF:    seg_o = SEG_HEX_F;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_mux_driver.sv
// -----------------------------------------------------------------------------
// seg7_mux_driver
// Time-multiplexed driver for a NUM_DIGITS common-anode style 7-segment display.
// Each digit is driven for REFRESH_DIV clk cycles; new data loaded through
// load/value/dp is held pending and only copied to the display register at the
// end of a complete frame, so a frame never mixes old and new data.
//
// Parameters:
//   NUM_DIGITS  (1..8)   number of multiplexed digits
//   REFRESH_DIV (>=2)    clk cycles per digit slot
// Ports:
//   clk                        system clock (rising edge)
//   rst_n                      asynchronous active-low reset
//   enable                     scan enable; low blanks the display
//   load                       one-cycle strobe capturing value/dp
//   value [4*NUM_DIGITS-1:0]   nibble k -> digit k (digit 0 rightmost)
//   dp    [NUM_DIGITS-1:0]     decimal point per digit, 1 = lit
//   seg_n [7:0]                active-low segments, bit0..6 = a..g, bit7 = dp
//   dig_n [NUM_DIGITS-1:0]     active-low digit selects, at most one low
//   upd_ack                    one-cycle pulse when captured data is transferred
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, segments a..g are switched off
//   on digits above the most significant non-zero nibble (digit 0 is never
//   blanked; decimal points still show).
// -----------------------------------------------------------------------------
module seg7_mux_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    upd_ack
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = NUM_DIGITS'(1);

    // Scan state
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Display and pending data
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_q, pend_d;

    // Registered outputs
    logic [7:0]              seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]   dig_n_q, dig_n_d;
    logic                    upd_ack_q, upd_ack_d;

    // Combinational helpers
    logic                    cnt_wrap_s;
    logic                    frame_end_s;
    logic                    xfer_s;
    logic [3:0]              nib_s;
    logic                    dp_sel_s;
    logic [6:0]              dec_seg_s;
    logic [6:0]              seg_act_s;
    logic                    blank_s;

    // Refresh counter and scan index; disabled scanning parks both at zero
    always_comb begin
        cnt_wrap_s  = (cnt_q == CNT_LAST);
        frame_end_s = 1'b1;
        cnt_d       = {CNT_W{1'b0}};
        idx_d       = {IDX_W{1'b0}};
        if (enable) begin
            frame_end_s = cnt_wrap_s && (idx_q == IDX_LAST);
            if (cnt_wrap_s) begin
                cnt_d = {CNT_W{1'b0}};
                idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : (idx_q + IDX_ONE);
            end else begin
                cnt_d = cnt_q + CNT_ONE;
                idx_d = idx_q;
            end
        end else begin
            // While blanked, any pending data may move across immediately
            frame_end_s = 1'b1;
            cnt_d       = {CNT_W{1'b0}};
            idx_d       = {IDX_W{1'b0}};
        end
    end

    // Pending capture and frame-end transfer; a load in the transfer cycle
    // bypasses the pending register so the newest data is what gets shown
    always_comb begin
        xfer_s     = frame_end_s && (pend_q || load);
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        pend_d     = pend_q;
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
        end else begin
            pend_val_d = pend_val_q;
            pend_dp_d  = pend_dp_q;
        end
        if (xfer_s) begin
            disp_val_d = load ? value : pend_val_q;
            disp_dp_d  = load ? dp : pend_dp_q;
            pend_d     = 1'b0;
        end else if (load) begin
            pend_d     = 1'b1;
        end else begin
            pend_d     = pend_q;
        end
        upd_ack_d = xfer_s;
    end

    // One-hot AND-OR select of the nibble and decimal point for the scanned digit
    always_comb begin
        nib_s    = 4'h0;
        dp_sel_s = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s    = nib_s | (disp_val_q[4*k +: 4] & {4{idx_q == IDX_W'(k)}});
            dp_sel_s = dp_sel_s | (disp_dp_q[k] & (idx_q == IDX_W'(k)));
        end
    end

    seg7_hex_decode u_hex_decode (
        .nibble_i (nib_s),
        .seg_o    (dec_seg_s)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_s;

    // Find the most significant non-zero nibble; digits above it are blanked.
    // msd_s stays 0 for an all-zero value so digit 0 always shows.
    always_comb begin
        msd_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            msd_s = (disp_val_q[4*k +: 4] != 4'h0) ? IDX_W'(k) : msd_s;
        end
        blank_s = (idx_q > msd_s);
    end
`else
    assign blank_s = 1'b0;
`endif

    // Next output word: inverted segments and one-hot-low digit select
    always_comb begin
        seg_act_s = blank_s ? SEG_BLANK : dec_seg_s;
        if (enable) begin
            seg_n_d = ~seg7_pack(seg_act_s, dp_sel_s);
            dig_n_d = ~(DIG_ONE << idx_q);
        end else begin
            seg_n_d = 8'hFF;
            dig_n_d = {NUM_DIGITS{1'b1}};
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= {CNT_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            disp_val_q <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_q  <= {NUM_DIGITS{1'b0}};
            pend_val_q <= {(4*NUM_DIGITS){1'b0}};
            pend_dp_q  <= {NUM_DIGITS{1'b0}};
            pend_q     <= 1'b0;
            seg_n_q    <= 8'hFF;
            dig_n_q    <= {NUM_DIGITS{1'b1}};
            upd_ack_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            seg_n_q    <= seg_n_d;
            dig_n_q    <= dig_n_d;
            upd_ack_q  <= upd_ack_d;
        end
    end

    assign seg_n   = seg_n_q;
    assign dig_n   = dig_n_q;
    assign upd_ack = upd_ack_q;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_mux_driver
// Self-checking bench for seg7_mux_driver with NUM_DIGITS=4, REFRESH_DIV=4.
// The reference model tracks a single scan-phase count t: digit = (t/DIV)%ND,
// frame end when t%FRAME == FRAME-1, and the outputs seen after an edge
// reflect the model state before that edge.
// Define SEG7_LEADING_ZERO_BLANK_EN for both RTL and bench to cover blanking.
// -----------------------------------------------------------------------------
module tb_seg7_mux_driver;

    localparam int ND    = 4;
    localparam int DIV   = 4;
    localparam int FRAME = ND * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic        upd_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    int          m_t;
    logic [15:0] m_disp_val;
    logic [3:0]  m_disp_dp;
    logic [15:0] m_pend_val;
    logic [3:0]  m_pend_dp;
    logic        m_pend;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic        exp_ack;

    seg7_mux_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .load    (load),
        .value   (value),
        .dp      (dp),
        .seg_n   (seg_n),
        .dig_n   (dig_n),
        .upd_ack (upd_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  4'hF: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [7:0] model_seg(input int digit, input logic [15:0] v, input logic [3:0] d);
        logic [6:0] segs;
        segs = hex_pat(v[digit*4 +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        begin
            int hi;
            hi = 0;
            for (int k = 0; k < ND; k++)
                if (v[k*4 +: 4] != 4'h0) hi = k;
            if (digit > hi) segs = 7'h00;
        end
`endif
        return ~{d[digit], segs};
    endfunction

    task automatic model_reset();
        m_t        = 0;
        m_disp_val = 16'h0000;
        m_disp_dp  = 4'h0;
        m_pend_val = 16'h0000;
        m_pend_dp  = 4'h0;
        m_pend     = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, and sample #1 after the edge
    task automatic step(input logic en, input logic ld, input logic [15:0] v, input logic [3:0] d);
        int   digit;
        logic fe;
        logic xf;
        enable = en;
        load   = ld;
        value  = v;
        dp     = d;
        @(posedge clk);
        digit = (m_t % FRAME) / DIV;
        if (en) begin
            exp_seg = model_seg(digit, m_disp_val, m_disp_dp);
            exp_dig = ~(4'b0001 << digit);
        end else begin
            exp_seg = 8'hFF;
            exp_dig = 4'hF;
        end
        fe = !en || ((m_t % FRAME) == FRAME - 1);
        xf = fe && (m_pend || ld);
        exp_ack = xf;
        if (xf) begin
            m_disp_val = ld ? v : m_pend_val;
            m_disp_dp  = ld ? d : m_pend_dp;
            m_pend     = 1'b0;
        end else if (ld) begin
            m_pend = 1'b1;
        end
        if (ld) begin
            m_pend_val = v;
            m_pend_dp  = d;
        end
        m_t = en ? m_t + 1 : 0;
        #1;
    endtask

    task automatic advance_to(input int phase);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((m_t % FRAME) == phase) break;
            step(1'b1, 1'b0, 16'h0000, 4'h0);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        load   = 1'b0;
        value  = 16'h0000;
        dp     = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (seg_n !== 8'hFF) begin tests_failed++; $display("FAIL reset_seg: got %h expected ff", seg_n); end
        tests_run++; if (dig_n !== 4'hF) begin tests_failed++; $display("FAIL reset_dig: got %h expected f", dig_n); end
        tests_run++; if (upd_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b expected 0", upd_ack); end
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (seg_n !== 8'hC0) begin tests_failed++; $display("FAIL first_seg: got %h expected c0", seg_n); end
        tests_run++; if (dig_n !== 4'hE) begin tests_failed++; $display("FAIL first_dig: got %h expected e", dig_n); end
    endtask

    task automatic test_basic_load();
        logic [3:0] dig_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] seg_tbl [4] = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        bit got;
        int extra;
        got   = 1'b0;
        extra = 0;
        step(1'b1, 1'b1, 16'h12AF, 4'h0);
        for (int i = 0; i < 2 * FRAME && !got; i++) begin
            step(1'b1, 1'b0, 16'h0000, 4'h0);
            tests_run++;
            if (seg_n !== exp_seg || dig_n !== exp_dig) begin
                tests_failed++; $display("FAIL basic_wait: got %h/%h expected %h/%h", dig_n, seg_n, exp_dig, exp_seg);
            end
            if (upd_ack === 1'b1) got = 1'b1;
        end
        tests_run++; if (!got) begin tests_failed++; $display("FAIL basic_ack: got no upd_ack expected one pulse"); end
        for (int s = 0; s < FRAME; s++) begin
            step(1'b1, 1'b0, 16'h0000, 4'h0);
            tests_run++;
            if (dig_n !== dig_tbl[s/DIV] || seg_n !== seg_tbl[s/DIV]) begin
                tests_failed++; $display("FAIL basic_slot%0d: got %h/%h expected %h/%h", s, dig_n, seg_n, dig_tbl[s/DIV], seg_tbl[s/DIV]);
            end
            if (upd_ack !== 1'b0) extra++;
        end
        tests_run++; if (extra != 0) begin tests_failed++; $display("FAIL basic_extra_ack: got %0d expected 0", extra); end
    endtask

    task automatic test_last_load_wins();
        int   acks;
        bit   after;
        logic [7:0] d0_seg;
        acks   = 0;
        after  = 1'b0;
        d0_seg = 8'h00;
        advance_to(1);
        step(1'b1, 1'b1, 16'h0000, 4'h0);
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        step(1'b1, 1'b1, 16'h0001, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b1, 1'b0, 16'h0000, 4'h0);
            tests_run++;
            if (seg_n !== exp_seg || dig_n !== exp_dig || upd_ack !== exp_ack) begin
                tests_failed++; $display("FAIL llw_cycle: got %h/%h/%b expected %h/%h/%b", dig_n, seg_n, upd_ack, exp_dig, exp_seg, exp_ack);
            end
            if (upd_ack === 1'b1) begin acks++; after = 1'b1; end
            else if (after && dig_n === 4'hE) d0_seg = seg_n;
        end
        tests_run++; if (acks != 1) begin tests_failed++; $display("FAIL llw_ack_count: got %0d expected 1", acks); end
        tests_run++; if (d0_seg !== 8'hF9) begin tests_failed++; $display("FAIL llw_digit0: got %h expected f9", d0_seg); end
    endtask

    task automatic test_coincident_load();
        advance_to(FRAME - 1);
        step(1'b1, 1'b1, 16'h3C5E, 4'h0);
        tests_run++; if (upd_ack !== 1'b1) begin tests_failed++; $display("FAIL coinc_ack: got %b expected 1", upd_ack); end
        tests_run++; if (seg_n !== exp_seg) begin tests_failed++; $display("FAIL coinc_old_seg: got %h expected %h", seg_n, exp_seg); end
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (dig_n !== 4'hE) begin tests_failed++; $display("FAIL coinc_dig: got %h expected e", dig_n); end
        tests_run++; if (seg_n !== 8'h86) begin tests_failed++; $display("FAIL coinc_seg: got %h expected 86", seg_n); end
        tests_run++; if (upd_ack !== 1'b0) begin tests_failed++; $display("FAIL coinc_ack_once: got %b expected 0", upd_ack); end
    endtask

    task automatic test_enable_low();
        advance_to(2 * DIV + 1);
        step(1'b1, 1'b1, 16'h4321, 4'h0);
        tests_run++; if (dig_n !== 4'hB || upd_ack !== 1'b0) begin tests_failed++; $display("FAIL en_pre: got %h/%b expected b/0", dig_n, upd_ack); end
        step(1'b0, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (seg_n !== 8'hFF) begin tests_failed++; $display("FAIL en_low_seg: got %h expected ff", seg_n); end
        tests_run++; if (dig_n !== 4'hF) begin tests_failed++; $display("FAIL en_low_dig: got %h expected f", dig_n); end
        tests_run++; if (upd_ack !== 1'b1) begin tests_failed++; $display("FAIL en_low_ack: got %b expected 1", upd_ack); end
        step(1'b0, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (upd_ack !== 1'b0 || seg_n !== 8'hFF) begin tests_failed++; $display("FAIL en_low_hold: got %h/%b expected ff/0", seg_n, upd_ack); end
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (dig_n !== 4'hE) begin tests_failed++; $display("FAIL en_rise_dig: got %h expected e", dig_n); end
        tests_run++; if (seg_n !== 8'hF9) begin tests_failed++; $display("FAIL en_rise_seg: got %h expected f9", seg_n); end
    endtask

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        logic [3:0] dig_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [7:0] seg_a   [4] = '{8'hC0, 8'h92, 8'h7F, 8'hFF};
        logic [7:0] seg_b   [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int pass = 0; pass < 2; pass++) begin
            advance_to(FRAME - 1);
            if (pass == 0) step(1'b1, 1'b1, 16'h0050, 4'b0100);
            else           step(1'b1, 1'b1, 16'h0000, 4'b0000);
            tests_run++; if (upd_ack !== 1'b1) begin tests_failed++; $display("FAIL lzb_ack%0d: got %b expected 1", pass, upd_ack); end
            for (int s = 0; s < FRAME; s++) begin
                step(1'b1, 1'b0, 16'h0000, 4'h0);
                tests_run++;
                if (dig_n !== dig_tbl[s/DIV] || seg_n !== ((pass == 0) ? seg_a[s/DIV] : seg_b[s/DIV])) begin
                    tests_failed++; $display("FAIL lzb%0d_slot%0d: got %h/%h expected %h/%h", pass, s, dig_n, seg_n,
                                             dig_tbl[s/DIV], (pass == 0) ? seg_a[s/DIV] : seg_b[s/DIV]);
                end
            end
        end
    endtask
`endif

    task automatic test_random();
        logic        en;
        logic        ld;
        logic [15:0] v;
        logic [3:0]  d;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 19) != 0);
            ld = ($urandom_range(0, 9) == 0);
            v  = 16'($urandom);
            d  = 4'($urandom_range(0, 15));
            step(en, ld, v, d);
            tests_run++;
            if (seg_n !== exp_seg || dig_n !== exp_dig || upd_ack !== exp_ack) begin
                tests_failed++; $display("FAIL random_%0d: got %h/%h/%b expected %h/%h/%b", i, dig_n, seg_n, upd_ack, exp_dig, exp_seg, exp_ack);
            end
        end
    endtask

    task automatic test_async_reset();
        advance_to(2 * DIV + 2);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (seg_n !== 8'hFF) begin tests_failed++; $display("FAIL async_seg: got %h expected ff", seg_n); end
        tests_run++; if (dig_n !== 4'hF) begin tests_failed++; $display("FAIL async_dig: got %h expected f", dig_n); end
        tests_run++; if (upd_ack !== 1'b0) begin tests_failed++; $display("FAIL async_ack: got %b expected 0", upd_ack); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 16'h0000, 4'h0);
        tests_run++; if (seg_n !== 8'hC0 || dig_n !== 4'hE) begin tests_failed++; $display("FAIL async_restart: got %h/%h expected e/c0", dig_n, seg_n); end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_last_load_wins();
        test_coincident_load();
        test_enable_low();
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
